// File: rtl/pixel_fb_writer.sv
// Pixel FIFO feeding a framebuffer write port with a full-frame clear engine; one write in flight, held until mem_ack.
// Optional off-screen clipping at push time is enabled by defining PIXEL_CLIP_EN.
module pixel_fb_writer #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned H_RES       = 320,
  parameter int unsigned V_RES       = 240,
  parameter logic [11:0] CLEAR_COLOR = 12'h000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [8:0]  X_in,
  input  logic [7:0]  Y_in,
  input  logic [11:0] Color_in,
  input  logic        writeEn_in,
  output logic        ready_out,
  output logic [16:0] mem_addr,
  output logic [11:0] mem_data,
  output logic        mem_we,
  input  logic        mem_ack,
  input  logic        clear_req,
  output logic        clear_done,
  output logic [7:0]  dropped_count,
  output logic        busy
);

  localparam int unsigned   PW        = $clog2(FIFO_DEPTH);
  localparam int unsigned   CW        = PW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [16:0]   LAST_ADDR = 17'(H_RES * V_RES - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] rd_next;
  logic [CW-1:0] count_q, count_d;
  logic [16:0]   mem_addr_q, mem_addr_d;
  logic [11:0]   mem_data_q, mem_data_d;
  logic          mem_we_q, mem_we_d;
  logic          clear_done_q, clear_done_d;
  logic [7:0]    dropped_q, dropped_d;

  logic [16:0]   addr_fifo  [FIFO_DEPTH];
  logic [11:0]   color_fifo [FIFO_DEPTH];

  logic          full;
  logic          clip;
  logic          push;
  logic          pop;
  logic          ack_ok;
  logic [16:0]   push_addr;

  // Y*320 + X as two shifts and adds; the maximum (82111) always fits 17 bits
  assign push_addr = ({9'd0, Y_in} << 8) + ({9'd0, Y_in} << 6) + {8'd0, X_in};

`ifdef PIXEL_CLIP_EN
  assign clip = ({23'd0, X_in} >= H_RES) || ({24'd0, Y_in} >= V_RES);
`else
  assign clip = 1'b0;
`endif

  assign full    = (count_q == FULL_CNT);
  assign push    = writeEn_in & ~full & ~clip;
  assign ack_ok  = mem_ack & mem_we_q;
  assign rd_next = rd_ptr_q + PW'(1);

  always_comb begin
    state_d      = state_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    clear_done_d = 1'b0;
    pop          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          state_d    = ST_CLEAR;
          mem_we_d   = 1'b1;
          mem_addr_d = '0;
          mem_data_d = CLEAR_COLOR;
        end else if (count_q != '0) begin
          state_d    = ST_WRITE;
          mem_we_d   = 1'b1;
          mem_addr_d = addr_fifo[rd_ptr_q];
          mem_data_d = color_fifo[rd_ptr_q];
        end
      end
      ST_WRITE: begin
        if (ack_ok) begin
          pop = 1'b1;
          // A pixel pushed in the same cycle the last entry retires is issued directly
          if (count_q > CW'(1)) begin
            mem_addr_d = addr_fifo[rd_next];
            mem_data_d = color_fifo[rd_next];
          end else if (push) begin
            mem_addr_d = push_addr;
            mem_data_d = Color_in;
          end else begin
            state_d  = ST_IDLE;
            mem_we_d = 1'b0;
          end
        end
      end
      ST_CLEAR: begin
        if (ack_ok) begin
          if (mem_addr_q == LAST_ADDR) begin
            state_d      = ST_IDLE;
            mem_we_d     = 1'b0;
            clear_done_d = 1'b1;
          end else begin
            mem_addr_d = mem_addr_q + 17'd1;
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        mem_we_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q + PW'(push);
    rd_ptr_d  = rd_ptr_q + PW'(pop);
    count_d   = count_q + CW'(push) - CW'(pop);
    dropped_d = dropped_q;
    if (writeEn_in && (full || clip) && (dropped_q != 8'hFF)) begin
      dropped_d = dropped_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      clear_done_q <= 1'b0;
      dropped_q    <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      clear_done_q <= clear_done_d;
      dropped_q    <= dropped_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count
  always_ff @(posedge clk) begin
    if (push) begin
      addr_fifo[wr_ptr_q]  <= push_addr;
      color_fifo[wr_ptr_q] <= Color_in;
    end
  end

  assign ready_out     = ~full;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_data      = mem_data_q;
  assign clear_done    = clear_done_q;
  assign dropped_count = dropped_q;
  assign busy          = (state_q != ST_IDLE) | (count_q != '0);

endmodule

// File: tb/tb_pixel_fb_writer.sv
// Bench for pixel_fb_writer: queue-based reference model checked every cycle, plus directed literal checks.
module tb_pixel_fb_writer;

  localparam int DEPTH = 8;
  localparam int NPIX  = 320 * 240;

  logic        clk;
  logic        resetn;
  logic [8:0]  X_in;
  logic [7:0]  Y_in;
  logic [11:0] Color_in;
  logic        writeEn_in;
  logic        ready_out;
  logic [16:0] mem_addr;
  logic [11:0] mem_data;
  logic        mem_we;
  logic        mem_ack;
  logic        clear_req;
  logic        clear_done;
  logic [7:0]  dropped_count;
  logic        busy;

  pixel_fb_writer dut (
    .clk(clk), .resetn(resetn),
    .X_in(X_in), .Y_in(Y_in), .Color_in(Color_in), .writeEn_in(writeEn_in),
    .ready_out(ready_out),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_ack(mem_ack),
    .clear_req(clear_req), .clear_done(clear_done),
    .dropped_count(dropped_count), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: pending pixels (head is the one on the bus), mode 0 idle / 1 pixel / 2 clear
  typedef logic [28:0] ent_t;
  ent_t m_q[$];
  int   m_mode  = 0;
  int   m_caddr = 0;
  int   m_drop  = 0;
  bit   m_done  = 1'b0;
  bit   m_full, m_clip, m_acc;
  int   m_a;

  always @(posedge clk) begin
    if (resetn) begin
      m_q.delete();
      m_mode  = 0;
      m_caddr = 0;
      m_drop  = 0;
      m_done  = 1'b0;
    end else begin
      m_full = (m_q.size() >= DEPTH);
      m_clip = 1'b0;
`ifdef PIXEL_CLIP_EN
      m_clip = (X_in >= 320) || (Y_in >= 240);
`endif
      m_acc = writeEn_in && !m_full && !m_clip;
      if (writeEn_in && !m_acc && m_drop < 255) m_drop++;
      m_a = (int'(Y_in) * 320 + int'(X_in)) % 131072;
      m_done = 1'b0;
      case (m_mode)
        0: begin
          if (clear_req) begin
            m_mode  = 2;
            m_caddr = 0;
          end else if (m_q.size() != 0) begin
            m_mode = 1;
          end
          if (m_acc) m_q.push_back({m_a[16:0], Color_in});
        end
        1: begin
          if (mem_ack) void'(m_q.pop_front());
          if (m_acc) m_q.push_back({m_a[16:0], Color_in});
          if (m_q.size() == 0) m_mode = 0;
        end
        default: begin
          if (mem_ack) begin
            if (m_caddr == NPIX - 1) begin
              m_mode = 0;
              m_done = 1'b1;
            end else begin
              m_caddr++;
            end
          end
          if (m_acc) m_q.push_back({m_a[16:0], Color_in});
        end
      endcase
    end
  end

  bit chk_en   = 1'b0;
  int wr_cnt   = 0;
  int done_cnt = 0;

  always @(negedge clk) begin
    if (mem_we && mem_ack) wr_cnt++;
    if (clear_done) done_cnt++;
    if (chk_en) begin
      check("mem_we", mem_we, m_mode != 0);
      if (m_mode == 1) begin
        check("pix_addr", mem_addr, m_q[0][28:12]);
        check("pix_data", mem_data, m_q[0][11:0]);
      end else if (m_mode == 2) begin
        check("clr_addr", mem_addr, m_caddr);
        check("clr_data", mem_data, 0);
      end
      check("ready_out", ready_out, m_q.size() < DEPTH);
      check("clear_done", clear_done, m_done);
      check("dropped_count", dropped_count, m_drop);
      check("busy", busy, (m_mode != 0) || (m_q.size() != 0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    writeEn_in = 1'b0;
    clear_req  = 1'b0;
    resetn     = 1'b1;
    tick();
    tick();
    resetn = 1'b0;
  endtask

  task automatic drive_pix(input int x, input int y, input int c);
    X_in       = 9'(x);
    Y_in       = 8'(y);
    Color_in   = 12'(c);
    writeEn_in = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  int w0, d0;
  bit hit;

  initial begin
    resetn = 1'b1; mem_ack = 1'b0; clear_req = 1'b0; writeEn_in = 1'b0;
    X_in = '0; Y_in = '0; Color_in = '0;
    do_reset();
    @(negedge clk);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_data", mem_data, 0);
    check("rst_ready", ready_out, 1);
    check("rst_busy", busy, 0);
    check("rst_dropped", dropped_count, 0);
    check("rst_clear_done", clear_done, 0);
    chk_en = 1'b1;

    // Single pixel, first-write latency and address
    mem_ack = 1'b1;
    drive_pix(10, 20, 12'hF00);
    tick();
    writeEn_in = 1'b0;
    @(negedge clk);
    check("lat_we_early", mem_we, 0);
    tick();
    @(negedge clk);
    check("lat_we", mem_we, 1);
    check("lat_addr", mem_addr, 6410);
    check("lat_data", mem_data, 12'hF00);
    tick();
    @(negedge clk);
    check("lat_we_done", mem_we, 0);
    check("lat_busy", busy, 0);

    // Fill under a stalled memory, one overflow, ignored clear_req while writing
    do_reset();
    mem_ack = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive_pix(i * 7, i + 3, 12'h100 + i);
      tick();
    end
    writeEn_in = 1'b0;
    clear_req  = 1'b1;
    tick();
    clear_req = 1'b0;
    @(negedge clk);
    check("ovf_ready", ready_out, 0);
    check("ovf_dropped", dropped_count, 1);
    w0 = wr_cnt;
    mem_ack = 1'b1;
    repeat (12) tick();
    check("ovf_writes", wr_cnt - w0, 8);
    check("ovf_idle", busy, 0);

    // Off-screen coordinates
    do_reset();
    mem_ack = 1'b1;
    w0 = wr_cnt;
    drive_pix(320, 0, 12'hABC);
    tick();
    drive_pix(0, 240, 12'h123);
    tick();
    writeEn_in = 1'b0;
    repeat (5) tick();
`ifdef PIXEL_CLIP_EN
    check("clip_dropped", dropped_count, 2);
    check("clip_writes", wr_cnt - w0, 0);
`else
    check("noclip_dropped", dropped_count, 0);
    check("noclip_writes", wr_cnt - w0, 2);
`endif

    // Sustained push/pop at occupancy 4, then prove occupancy by refilling
    do_reset();
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_pix(i, i, 12'h200 + i);
      tick();
    end
    mem_ack = 1'b1;
    for (int i = 0; i < 50; i++) begin
      drive_pix($urandom_range(0, 319), $urandom_range(0, 239), $urandom_range(0, 4095));
      tick();
    end
    check("steady_dropped", dropped_count, 0);
    check("steady_ready", ready_out, 1);
    mem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_pix(i + 100, i, 12'h300 + i);
      tick();
    end
    writeEn_in = 1'b0;
    check("steady_refill_drop", dropped_count, 1);
    mem_ack = 1'b1;
    repeat (12) tick();

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      writeEn_in = ($urandom_range(0, 99) < 60);
      mem_ack    = $urandom_range(0, 1);
      X_in       = ($urandom_range(0, 99) < 90) ? 9'($urandom_range(0, 319)) : 9'($urandom_range(0, 511));
      Y_in       = ($urandom_range(0, 99) < 90) ? 8'($urandom_range(0, 239)) : 8'($urandom_range(0, 255));
      Color_in   = 12'($urandom_range(0, 4095));
      tick();
    end
    writeEn_in = 1'b0;
    mem_ack    = 1'b1;
    repeat (20) tick();
    check("rand_drained", busy, 0);

    // Reset in the middle of a clear
    do_reset();
    mem_ack = 1'b1;
    d0 = done_cnt;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      tick();
      if (mem_addr == 17'd500) hit = 1'b1;
    end
    check("abort_reached_500", hit, 1);
    resetn = 1'b1;
    tick();
    resetn = 1'b0;
    @(negedge clk);
    check("abort_we", mem_we, 0);
    check("abort_busy", busy, 0);
    repeat (5) tick();
    check("abort_no_done", done_cnt - d0, 0);

    // Full-frame clear with pixels queued mid-clear and an ignored clear_req
    do_reset();
    mem_ack = 1'b1;
    w0 = wr_cnt;
    d0 = done_cnt;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (100) tick();
    for (int i = 0; i < 3; i++) begin
      drive_pix(300 + i, 200 + i, 12'hA50 + i);
      tick();
    end
    writeEn_in = 1'b0;
    clear_req  = 1'b1;
    tick();
    clear_req = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 78000 && !hit; i++) begin
      tick();
      if (clear_done) hit = 1'b1;
    end
    check("clear_finished", hit, 1);
    repeat (10) tick();
    check("clear_done_pulses", done_cnt - d0, 1);
    check("clear_total_writes", wr_cnt - w0, NPIX + 3);
    check("clear_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_fb_writer.md
PIXEL_FB_WRITER -- requirements
Module: pixel_fb_writer

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 8, meaning pixel FIFO entries (power of two).
REQ-002 The block SHALL have parameter H_RES, default 320, meaning framebuffer width in pixels.
REQ-003 The block SHALL have parameter V_RES, default 240, meaning framebuffer height in pixels.
REQ-004 The block SHALL have parameter CLEAR_COLOR, default 12'h000, meaning fill value for a clear.
REQ-005 The block SHALL have port clk, input, 1 bit, meaning the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port resetn, input, 1 bit, meaning reset, synchronous and active-high.
REQ-007 The block SHALL have ports X_in (input, 9 bits), Y_in (input, 8 bits) and Color_in (input, 12 bits), meaning the pixel coordinate and RGB444 colour.
REQ-008 The block SHALL have port writeEn_in, input, 1 bit, meaning a pixel is offered this cycle.
REQ-009 The block SHALL have port ready_out, output, 1 bit, meaning the FIFO can accept a pixel this cycle.
REQ-010 The block SHALL have ports mem_addr (output, 17 bits), mem_data (output, 12 bits) and mem_we (output, 1 bit), meaning the framebuffer write port; mem_ack is an input, 1 bit, meaning the memory accepted the write.
REQ-011 The block SHALL have port clear_req, input, 1 bit, and port clear_done, output, 1 bit, meaning a full-frame clear request and its one-cycle completion pulse.
REQ-012 The block SHALL have port dropped_count, output, 8 bits, meaning pixels lost, and port busy, output, 1 bit, meaning the FSM is not IDLE or the FIFO is non-empty.

Function
REQ-013 ready_out SHALL equal NOT full; a push SHALL occur only when writeEn_in and ready_out are both 1.
REQ-014 If writeEn_in is 1 while the FIFO is full, the pixel SHALL be discarded and dropped_count SHALL increment, saturating at 255.
REQ-015 A push and a pop in the same cycle SHALL leave the FIFO count unchanged.
REQ-016 At a full FIFO with a pop, ready_out SHALL still be 0 in that cycle; no push SHALL occur that cycle.
REQ-017 The write address SHALL be Y*320+X, computed as (Y<<8)+(Y<<6)+X into 17 bits with no multiplier.
REQ-018 The FSM SHALL have the states IDLE, WRITE and CLEAR.
REQ-019 In IDLE, the FSM SHALL go to CLEAR if clear_req is 1; otherwise it SHALL go to WRITE if the FIFO is non-empty; clear_req SHALL take priority.
REQ-020 In WRITE, mem_we, mem_addr and mem_data SHALL be registered and held stable until mem_ack=1; on mem_ack the entry SHALL pop.
REQ-021 After the mem_ack in WRITE, the FSM SHALL issue the next entry with no idle cycle if one exists, and SHALL otherwise return to IDLE.
REQ-022 Latency: a pixel pushed into an empty FIFO at edge N SHALL drive mem_we=1 after edge N+1.
REQ-023 In CLEAR, the block SHALL write CLEAR_COLOR to addresses 0 .. H_RES*V_RES-1 in order, each held until mem_ack.
REQ-024 After the final ack of a clear, clear_done SHALL pulse for one cycle and the FSM SHALL enter IDLE.
REQ-025 Pushes SHALL still be accepted during CLEAR; FIFO contents SHALL drain only after the clear.
REQ-026 clear_req SHALL be ignored outside IDLE.
REQ-027 mem_ack SHALL be ignored while mem_we=0.

Reset
REQ-028 While resetn=1 at a clock edge, the block SHALL empty the FIFO and force the FSM to IDLE.
REQ-029 While resetn=1 at a clock edge, the block SHALL set mem_we, clear_done, busy, dropped_count, mem_addr and mem_data to 0, and ready_out SHALL be 1 afterward.
REQ-030 A reset during WRITE or CLEAR SHALL abandon the operation without completing it, and clear_done SHALL not pulse.

Configuration
REQ-031 With PIXEL_CLIP_EN defined, a pixel with X>=H_RES or Y>=V_RES SHALL be discarded at push time and SHALL increment dropped_count; ready_out SHALL be unaffected.
REQ-032 Without PIXEL_CLIP_EN, all pixels SHALL be accepted and written at the computed address, truncated to 17 bits.

Verification
REQ-033 Bench: push (10,20,12'hF00) with mem_ack tied to 1 -> mem_we=1 one cycle later with mem_addr=6410 and mem_data=12'hF00, then busy=0.
REQ-034 Bench: hold mem_ack=0 and push 9 pixels -> 8 accepted, ready_out=0, dropped_count=1; after mem_ack is released, 8 writes occur in push order.
REQ-035 Bench: clear_req in IDLE with mem_ack=1 -> 76800 writes of 12'h000 to addresses 0..76799, then clear_done high for exactly one cycle.
REQ-036 Bench: with PIXEL_CLIP_EN defined, push (320,0) and (0,240) -> no mem_we and dropped_count=2.
REQ-037 Bench: assert resetn at address 500 of a clear -> mem_we=0 and FSM in IDLE next cycle, with no clear_done pulse.
REQ-038 Bench: sustained push and pop at a count of 4 with mem_ack=1 -> count stays 4 and no drops occur.
